// File: rtl/network_vc_input_buffer.sv
// network_vc_input_buffer
//
// Input stage of one NoC router port, on the receiving end of a tile-to-tile
// link. Incoming flits are sorted into one FIFO per virtual channel. A
// per-VC go bit tells the upstream tile whether it may keep sending on that
// VC. Buffered flits are drained one per cycle, round-robin across the VCs,
// into a registered valid/ready output that feeds the crossbar.
//
// Ports
//   clk_network_i    network clock
//   rst_network_ni   asynchronous, active-low reset
//   network_valid_i  link flit valid
//   network_data_i   link flit {vc_id, broadcast, flit_type, flit}
//   network_go_o     per-VC go (1 = upstream may send on that VC)
//   data_o           buffered flit to the crossbar, same packing
//   valid_o          data_o valid
//   ready_i          crossbar accepts data_o
//   overflow_o       sticky: a flit was dropped because its VC FIFO was full
//   bad_vc_o         sticky: a flit arrived with an out-of-range vc_id
module network_vc_input_buffer #(
    parameter int FlitWidth               = 64,
    parameter int FlitTypeWidth           = 2,
    parameter int BroadcastWidth          = 1,
    parameter int VirtualChannelIdWidth   = 2,
    parameter int NumberOfVirtualChannels = 3,
    parameter int BufferDepth             = 4,
    parameter int GoThreshold             = 2,
    localparam int DataWidth = FlitWidth + FlitTypeWidth + BroadcastWidth + VirtualChannelIdWidth
) (
    input  logic                               clk_network_i,
    input  logic                               rst_network_ni,
    input  logic                               network_valid_i,
    input  logic [DataWidth-1:0]               network_data_i,
    output logic [NumberOfVirtualChannels-1:0] network_go_o,
    output logic [DataWidth-1:0]               data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               overflow_o,
    output logic                               bad_vc_o
);

    localparam int NumVc    = NumberOfVirtualChannels;
    localparam int VcWidth  = VirtualChannelIdWidth;
    localparam int PtrWidth = $clog2(BufferDepth);
    localparam int CntWidth = $clog2(BufferDepth + 1);

    localparam logic [CntWidth-1:0] DepthCount = CntWidth'(BufferDepth);
    localparam logic [CntWidth-1:0] GoLimit    = CntWidth'(BufferDepth - GoThreshold);
    localparam logic [VcWidth:0]    NumVcExt   = (VcWidth + 1)'(NumVc);
    localparam logic [VcWidth-1:0]  LastVc     = VcWidth'(NumVc - 1);

    logic [DataWidth-1:0] mem [NumVc][BufferDepth];
    logic [PtrWidth-1:0]  wr_ptr [NumVc];
    logic [PtrWidth-1:0]  rd_ptr [NumVc];
    logic [CntWidth-1:0]  count [NumVc];
    logic [CntWidth-1:0]  count_next [NumVc];

    logic [VcWidth-1:0] in_vc;
    logic               in_vc_ok;
    logic               load;
    logic [VcWidth-1:0] last_grant;
    logic [VcWidth-1:0] grant;
    logic               grant_found;
    int                 arb_idx;
    logic [NumVc-1:0]   wr_en;
    logic [NumVc-1:0]   pop;
    logic               drop_full;

    assign in_vc    = network_data_i[DataWidth-1 -: VcWidth];
    assign in_vc_ok = {1'b0, in_vc} < NumVcExt;

    // The output register takes a new flit whenever it is empty or being
    // consumed this cycle.
    assign load = !valid_o || ready_i;

    // Round-robin search starting just after the last granted VC.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        arb_idx     = 0;
        for (int i = 1; i <= NumVc; i++) begin
            arb_idx = (int'(last_grant) + i) % NumVc;
            if (!grant_found && count[arb_idx] != '0) begin
                grant_found = 1'b1;
                grant       = VcWidth'(arb_idx);
            end
        end
    end

    // A full FIFO can still accept a flit if it is popped on the same edge.
    always_comb begin
        wr_en     = '0;
        pop       = '0;
        drop_full = 1'b0;
        for (int v = 0; v < NumVc; v++) begin
            pop[v] = load && grant_found && (grant == VcWidth'(v));
            if (network_valid_i && in_vc_ok && (in_vc == VcWidth'(v))) begin
                if ((count[v] < DepthCount) || pop[v]) begin
                    wr_en[v] = 1'b1;
                end else begin
                    drop_full = 1'b1;
                end
            end
            count_next[v] = count[v] + CntWidth'(wr_en[v]) - CntWidth'(pop[v]);
        end
    end

    // Storage has no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk_network_i) begin
        for (int v = 0; v < NumVc; v++) begin
            if (wr_en[v]) begin
                mem[v][wr_ptr[v]] <= network_data_i;
            end
        end
    end

    // Pointers, counters, go flags, output register and sticky errors.
    always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
        if (!rst_network_ni) begin
            for (int v = 0; v < NumVc; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            network_go_o <= '1;
            data_o       <= '0;
            valid_o      <= 1'b0;
            last_grant   <= LastVc;
            overflow_o   <= 1'b0;
            bad_vc_o     <= 1'b0;
        end else begin
            for (int v = 0; v < NumVc; v++) begin
                count[v] <= count_next[v];
                if (wr_en[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + 1'b1;
                end
                if (pop[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + 1'b1;
                end
                network_go_o[v] <= count_next[v] < GoLimit;
            end
            if (load) begin
                if (grant_found) begin
                    data_o     <= mem[grant][rd_ptr[grant]];
                    valid_o    <= 1'b1;
                    last_grant <= grant;
                end else begin
                    valid_o <= 1'b0;
                end
            end
            overflow_o <= overflow_o | drop_full;
            bad_vc_o   <= bad_vc_o | (network_valid_i && !in_vc_ok);
        end
    end

endmodule

// File: tb/tb_network_vc_input_buffer.sv
// tb_network_vc_input_buffer
//
// Directed bench for network_vc_input_buffer with default parameters.
// Expected output flits are queued when stimulus is issued; a monitor pops
// and compares each flit the crossbar side accepts.
module tb_network_vc_input_buffer;

    localparam int DataWidth = 69;

    logic                 clk;
    logic                 rst_n;
    logic                 network_valid;
    logic [DataWidth-1:0] network_data;
    logic [2:0]           network_go;
    logic [DataWidth-1:0] data_out;
    logic                 valid_out;
    logic                 ready;
    logic                 overflow;
    logic                 bad_vc;

    int checks = 0;
    int errors = 0;
    logic [DataWidth-1:0] sb [$];

    network_vc_input_buffer dut (
        .clk_network_i  (clk),
        .rst_network_ni (rst_n),
        .network_valid_i(network_valid),
        .network_data_i (network_data),
        .network_go_o   (network_go),
        .data_o         (data_out),
        .valid_o        (valid_out),
        .ready_i        (ready),
        .overflow_o     (overflow),
        .bad_vc_o       (bad_vc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flits carry broadcast=0 and flit_type=2'b10 throughout.
    function automatic logic [DataWidth-1:0] pack(input logic [1:0] vc, input logic [63:0] payload);
        return {vc, 1'b0, 2'b10, payload};
    endfunction

    task automatic check_output(input string name, input logic [DataWidth-1:0] actual,
                                input logic [DataWidth-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] vc, input logic [63:0] payload);
        network_valid = valid;
        network_data  = pack(vc, payload);
    endtask

    // Send one flit for one cycle; optionally record it as expected output.
    task automatic send_flit(input logic [1:0] vc, input logic [63:0] payload, input bit expect_out);
        apply_stimulus(1'b1, vc, payload);
        if (expect_out) sb.push_back(pack(vc, payload));
        tick();
        network_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check_output(name, DataWidth'(sb.size()), '0);
    endtask

    // Monitor: every accepted output flit must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_flit actual=%h required=none", data_out);
            end else begin
                logic [DataWidth-1:0] exp_flit;
                exp_flit = sb.pop_front();
                if (data_out !== exp_flit) begin
                    errors++;
                    $display("[TB] FAIL output_flit actual=%h required=%h", data_out, exp_flit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        network_valid = 1'b0;
        network_data  = '0;
        ready         = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_go", DataWidth'(network_go), DataWidth'(3'b111));
        check_output("reset_valid", DataWidth'(valid_out), '0);
        check_output("reset_data", data_out, '0);
        check_output("reset_overflow", DataWidth'(overflow), '0);
        check_output("reset_bad_vc", DataWidth'(bad_vc), '0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single flit, two-cycle latency
        $display("[TB] single flit latency");
        ready = 1'b1;
        send_flit(2'd1, 64'hA5, 1'b1);
        @(negedge clk);
        check_output("latency_early_valid", DataWidth'(valid_out), '0);
        check_output("latency_go_after_write", DataWidth'(network_go), DataWidth'(3'b111));
        tick();
        @(negedge clk);
        check_output("latency_valid", DataWidth'(valid_out), DataWidth'(1'b1));
        check_output("latency_data", data_out, pack(2'd1, 64'hA5));
        check_output("latency_go", DataWidth'(network_go), DataWidth'(3'b111));
        wait_drain("drain_single");
        tick();

        // Go backpressure on VC0
        $display("[TB] go backpressure");
        ready = 1'b0;
        send_flit(2'd0, 64'd1, 1'b1);
        send_flit(2'd0, 64'd2, 1'b1);
        send_flit(2'd0, 64'd3, 1'b1);
        @(negedge clk);
        check_output("bp_go_low", DataWidth'(network_go), DataWidth'(3'b110));
        check_output("bp_hold_data", data_out, pack(2'd0, 64'd1));
        tick();
        @(negedge clk);
        check_output("bp_go_still_low", DataWidth'(network_go), DataWidth'(3'b110));
        check_output("bp_still_held", data_out, pack(2'd0, 64'd1));
        tick();
        ready = 1'b1;
        wait_drain("drain_backpressure");
        tick();
        @(negedge clk);
        check_output("bp_go_restored", DataWidth'(network_go), DataWidth'(3'b111));
        tick();

        // Round-robin fairness: expected order is interleaved across VCs
        $display("[TB] round robin");
        ready = 1'b0;
        sb.push_back(pack(2'd0, 64'd10));
        sb.push_back(pack(2'd1, 64'd20));
        sb.push_back(pack(2'd2, 64'd30));
        sb.push_back(pack(2'd0, 64'd11));
        sb.push_back(pack(2'd1, 64'd21));
        sb.push_back(pack(2'd2, 64'd31));
        send_flit(2'd0, 64'd10, 1'b0);
        send_flit(2'd0, 64'd11, 1'b0);
        send_flit(2'd1, 64'd20, 1'b0);
        send_flit(2'd1, 64'd21, 1'b0);
        send_flit(2'd2, 64'd30, 1'b0);
        send_flit(2'd2, 64'd31, 1'b0);
        tick();
        ready = 1'b1;
        wait_drain("drain_round_robin");
        tick();

        // Overflow on VC2: payload 5 is dropped
        $display("[TB] overflow");
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_flit(2'd2, 64'(i), i < 5);
            if (i == 4) check_output("overflow_not_yet", DataWidth'(overflow), '0);
        end
        @(negedge clk);
        check_output("overflow_set", DataWidth'(overflow), DataWidth'(1'b1));
        check_output("overflow_go", DataWidth'(network_go), DataWidth'(3'b011));
        check_output("overflow_no_bad_vc", DataWidth'(bad_vc), '0);
        tick();
        ready = 1'b1;
        wait_drain("drain_overflow");
        tick();
        @(negedge clk);
        check_output("overflow_sticky", DataWidth'(overflow), DataWidth'(1'b1));
        check_output("overflow_go_restored", DataWidth'(network_go), DataWidth'(3'b111));
        tick();

        // Bad VC id
        $display("[TB] bad vc");
        send_flit(2'd3, 64'h77, 1'b0);
        @(negedge clk);
        check_output("bad_vc_set", DataWidth'(bad_vc), DataWidth'(1'b1));
        repeat (3) tick();
        @(negedge clk);
        check_output("bad_vc_no_output", DataWidth'(valid_out), '0);
        check_output("bad_vc_sticky", DataWidth'(bad_vc), DataWidth'(1'b1));
        tick();

        // Reset with buffers partially full
        $display("[TB] reset mid-operation");
        ready = 1'b0;
        send_flit(2'd0, 64'h40, 1'b0);
        send_flit(2'd0, 64'h41, 1'b0);
        send_flit(2'd1, 64'h50, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("midreset_valid", DataWidth'(valid_out), '0);
        check_output("midreset_data", data_out, '0);
        check_output("midreset_go", DataWidth'(network_go), DataWidth'(3'b111));
        check_output("midreset_overflow", DataWidth'(overflow), '0);
        check_output("midreset_bad_vc", DataWidth'(bad_vc), '0);
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check_output("post_reset_no_flit", DataWidth'(valid_out), '0);
        check_output("final_scoreboard_empty", DataWidth'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
